// File: rtl/core_pkg.sv
// Shared core types: trap sequencer states, cause codes and the fetch redirect mux select.
// Pure declarations; no logic, no latency, no flow control.
package core_pkg;

   typedef enum logic {
      EXCPC_MTVEC = 1'b0,
      EXCPC_MEPC  = 1'b1
   } exc_pc_mux_t;

   localparam logic [4:0] EXC_CAUSE_INSTR_MISALIGN = 5'd0;
   localparam logic [4:0] EXC_CAUSE_INSTR_FAULT    = 5'd1;
   localparam logic [4:0] EXC_CAUSE_ILLEGAL_INSN   = 5'd2;
   localparam logic [4:0] EXC_CAUSE_BREAKPOINT     = 5'd3;
   localparam logic [4:0] EXC_CAUSE_LOAD_FAULT     = 5'd5;
   localparam logic [4:0] EXC_CAUSE_STORE_FAULT    = 5'd7;
   localparam logic [4:0] EXC_CAUSE_ECALL_MMODE    = 5'd11;

   localparam logic [4:0] IRQ_CAUSE_MSI = 5'd3;
   localparam logic [4:0] IRQ_CAUSE_MTI = 5'd7;
   localparam logic [4:0] IRQ_CAUSE_MEI = 5'd11;

   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      UPDATE   = 2'd2,
      REDIRECT = 2'd3
   } trap_state_t;

   // What the sequencer latched in IDLE; drives mcause MSB and the redirect source.
   localparam logic [1:0] KIND_EXC  = 2'd0;
   localparam logic [1:0] KIND_IRQ  = 2'd1;
   localparam logic [1:0] KIND_MRET = 2'd2;

endpackage

// File: rtl/trap_irq_prio.sv
// Masks machine interrupt lines with mie/mstatus.mie and picks the winner (ext > sw > timer).
// Purely combinational, zero latency; no flow control.
module trap_irq_prio
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            irq_sw_i,
   input  logic            irq_timer_i,
   input  logic            irq_ext_i,
   input  logic            mstatus_mie_i,
   input  logic [XLEN-1:0] mie_i,
   output logic            irq_pend_o,
   output logic [4:0]      irq_code_o
);

   logic ext_en;
   logic sw_en;
   logic timer_en;
   logic unused_mie;

   assign ext_en   = irq_ext_i   & mie_i[11];
   assign sw_en    = irq_sw_i    & mie_i[3];
   assign timer_en = irq_timer_i & mie_i[7];

   assign unused_mie = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

   always_comb begin
      irq_pend_o = mstatus_mie_i & (ext_en | sw_en | timer_en);
      irq_code_o = 5'd0;
      if (ext_en)
         irq_code_o = IRQ_CAUSE_MEI;
      else if (sw_en)
         irq_code_o = IRQ_CAUSE_MSI;
      else if (timer_en)
         irq_code_o = IRQ_CAUSE_MTI;
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: flush, CSR update strobes, fetch redirect. Optional TRAP_CTRL_VECTORED_EN.
// Latency: trap redirect 3 cycles after the event edge, MRET 2; FLUSH holds while lsu_busy_i (LSU_WAIT=1).
// Backpressure: events outside IDLE are ignored; the pipeline is stalled until the redirect.
module trap_ctrl
   import core_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int LSU_WAIT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            exc_valid_i,
   input  logic [4:0]      exc_cause_i,
   input  logic [XLEN-1:0] exc_pc_i,
   input  logic [XLEN-1:0] exc_tval_i,
   input  logic            mret_i,
   input  logic            mem_valid_i,
   input  logic [XLEN-1:0] mem_pc_i,
   input  logic            irq_sw_i,
   input  logic            irq_timer_i,
   input  logic            irq_ext_i,
   input  logic            mstatus_mie_i,
   input  logic [XLEN-1:0] mie_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            lsu_busy_i,
   output logic            stall_o,
   output logic            flush_o,
   output logic            mepc_we_o,
   output logic            mcause_we_o,
   output logic            mtval_we_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mcause_o,
   output logic [XLEN-1:0] mtval_o,
   output logic            mstatus_trap_o,
   output logic            mstatus_mret_o,
   output logic            pc_set_o,
   output exc_pc_mux_t     exc_pc_mux_o,
   output logic [XLEN-1:0] trap_target_o
);

   trap_state_t     state_q;
   logic [1:0]      kind_q;
   logic [4:0]      cause_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] tval_q;

   logic            irq_pend_raw;
   logic            irq_pend;
   logic [4:0]      irq_code;
   logic            lsu_hold;
   logic [XLEN-1:0] mtvec_base;
   logic [XLEN-1:0] trap_vec;

   trap_irq_prio #(.XLEN(XLEN)) u_irq_prio (
      .irq_sw_i      (irq_sw_i),
      .irq_timer_i   (irq_timer_i),
      .irq_ext_i     (irq_ext_i),
      .mstatus_mie_i (mstatus_mie_i),
      .mie_i         (mie_i),
      .irq_pend_o    (irq_pend_raw),
      .irq_code_o    (irq_code)
   );

   // Interrupts are only taken on an instruction boundary so mepc is a real PC.
   assign irq_pend   = irq_pend_raw & mem_valid_i;
   assign lsu_hold   = (LSU_WAIT != 0) && lsu_busy_i;
   assign mtvec_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
   assign trap_vec = ((mtvec_i[1:0] == MTVEC_MODE_VECTORED) && (kind_q == KIND_IRQ))
                   ? mtvec_base + {{(XLEN-7){1'b0}}, cause_q, 2'b00}
                   : mtvec_base;
`else
   logic unused_mode;
   assign unused_mode = ^mtvec_i[1:0];
   assign trap_vec    = mtvec_base;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         kind_q  <= KIND_EXC;
         cause_q <= '0;
         pc_q    <= '0;
         tval_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (exc_valid_i) begin
                  kind_q  <= KIND_EXC;
                  cause_q <= exc_cause_i;
                  pc_q    <= exc_pc_i;
                  tval_q  <= exc_tval_i;
                  state_q <= FLUSH;
               end else if (mret_i) begin
                  kind_q  <= KIND_MRET;
                  state_q <= FLUSH;
               end else if (irq_pend) begin
                  kind_q  <= KIND_IRQ;
                  cause_q <= irq_code;
                  pc_q    <= mem_pc_i;
                  tval_q  <= '0;
                  state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (!lsu_hold)
                  state_q <= (kind_q == KIND_MRET) ? REDIRECT : UPDATE;
            end
            UPDATE:   state_q <= REDIRECT;
            REDIRECT: state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from state so an async reset drops every strobe at once.
   always_comb begin
      stall_o        = 1'b0;
      flush_o        = 1'b0;
      mepc_we_o      = 1'b0;
      mcause_we_o    = 1'b0;
      mtval_we_o     = 1'b0;
      mepc_o         = '0;
      mcause_o       = '0;
      mtval_o        = '0;
      mstatus_trap_o = 1'b0;
      mstatus_mret_o = 1'b0;
      pc_set_o       = 1'b0;
      exc_pc_mux_o   = EXCPC_MTVEC;
      trap_target_o  = '0;
      case (state_q)
         FLUSH: begin
            stall_o = 1'b1;
            flush_o = 1'b1;
         end
         UPDATE: begin
            stall_o        = 1'b1;
            mepc_we_o      = 1'b1;
            mcause_we_o    = 1'b1;
            mtval_we_o     = 1'b1;
            mstatus_trap_o = 1'b1;
            mepc_o         = {pc_q[XLEN-1:1], 1'b0};
            mcause_o       = {(kind_q == KIND_IRQ), {(XLEN-6){1'b0}}, cause_q};
            mtval_o        = tval_q;
         end
         REDIRECT: begin
            stall_o  = 1'b1;
            pc_set_o = 1'b1;
            if (kind_q == KIND_MRET) begin
               exc_pc_mux_o   = EXCPC_MEPC;
               trap_target_o  = mepc_i;
               mstatus_mret_o = 1'b1;
            end else begin
               trap_target_o = trap_vec;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table of single events plus LSU-wait/priority and reset sequences.
module tb_trap_ctrl;
   import core_pkg::*;

`ifdef TRAP_CTRL_VECTORED_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_pc, exc_tval;
   logic        mret, mem_valid;
   logic [31:0] mem_pc;
   logic        irq_sw, irq_timer, irq_ext, gmie;
   logic [31:0] mie, mtvec, mepc_in;
   logic        lsu_busy;
   logic        stall, flush, mepc_we, mcause_we, mtval_we;
   logic [31:0] mepc_out, mcause_out, mtval_out;
   logic        mstatus_trap, mstatus_mret, pc_set;
   exc_pc_mux_t exc_pc_mux;
   logic [31:0] trap_target;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   trap_ctrl #(.XLEN(32), .LSU_WAIT(1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .exc_valid_i    (exc_valid),
      .exc_cause_i    (exc_cause),
      .exc_pc_i       (exc_pc),
      .exc_tval_i     (exc_tval),
      .mret_i         (mret),
      .mem_valid_i    (mem_valid),
      .mem_pc_i       (mem_pc),
      .irq_sw_i       (irq_sw),
      .irq_timer_i    (irq_timer),
      .irq_ext_i      (irq_ext),
      .mstatus_mie_i  (gmie),
      .mie_i          (mie),
      .mtvec_i        (mtvec),
      .mepc_i         (mepc_in),
      .lsu_busy_i     (lsu_busy),
      .stall_o        (stall),
      .flush_o        (flush),
      .mepc_we_o      (mepc_we),
      .mcause_we_o    (mcause_we),
      .mtval_we_o     (mtval_we),
      .mepc_o         (mepc_out),
      .mcause_o       (mcause_out),
      .mtval_o        (mtval_out),
      .mstatus_trap_o (mstatus_trap),
      .mstatus_mret_o (mstatus_mret),
      .pc_set_o       (pc_set),
      .exc_pc_mux_o   (exc_pc_mux),
      .trap_target_o  (trap_target)
   );

   // kind: 0 = no trap expected, 1 = trap, 2 = mret
   typedef struct {
      logic        exc;
      logic [4:0]  cause;
      logic [31:0] pc;
      logic [31:0] tval;
      logic        mret;
      logic [2:0]  irq;   // {ext, timer, sw}
      logic        gmie;
      logic        mem_valid;
      logic [31:0] mie;
      logic [31:0] mem_pc;
      logic [31:0] mtvec;
      logic [31:0] mepc_in;
      int          kind;
      logic [31:0] exp_mepc;
      logic [31:0] exp_mcause;
      logic [31:0] exp_mtval;
      logic [31:0] exp_target;
   } vec_t;

   localparam int NV = 10;
   vec_t vt[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_events();
      exc_valid = 1'b0;
      mret      = 1'b0;
      irq_sw    = 1'b0;
      irq_timer = 1'b0;
      irq_ext   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b1, 5'h02, 32'h100, 32'hDEADBEEF, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h80, 32'h0, 1, 32'h100, 32'h2, 32'hDEADBEEF, 32'h80};
      vt[1] = '{1'b0, 5'h00, 32'h0, 32'h0, 1'b0, 3'b010, 1'b1, 1'b1, 32'h80, 32'h204,
                32'h81, 32'h0, 1, 32'h204, 32'h80000007, 32'h0, VEC ? 32'h9C : 32'h80};
      vt[2] = '{1'b0, 5'h00, 32'h0, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'h80, 32'h204,
                32'h81, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
      vt[3] = '{1'b0, 5'h00, 32'h0, 32'h0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h80, 32'h340, 2, 32'h0, 32'h0, 32'h0, 32'h340};
      vt[4] = '{1'b1, 5'h0B, 32'h105, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h201, 32'h0, 1, 32'h104, 32'hB, 32'h0, 32'h200};
      vt[5] = '{1'b0, 5'h00, 32'h0, 32'h0, 1'b0, 3'b011, 1'b1, 1'b1, 32'h88, 32'h400,
                32'h101, 32'h0, 1, 32'h400, 32'h80000003, 32'h0, VEC ? 32'h10C : 32'h100};
      vt[6] = '{1'b0, 5'h00, 32'h0, 32'h0, 1'b0, 3'b101, 1'b1, 1'b1, 32'h808, 32'h500,
                32'h100, 32'h0, 1, 32'h500, 32'h8000000B, 32'h0, 32'h100};
      vt[7] = '{1'b0, 5'h00, 32'h0, 32'h0, 1'b0, 3'b010, 1'b1, 1'b1, 32'h8, 32'h600,
                32'h100, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
      vt[8] = '{1'b0, 5'h00, 32'h0, 32'h0, 1'b0, 3'b010, 1'b1, 1'b0, 32'h80, 32'h600,
                32'h100, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
      vt[9] = '{1'b1, 5'h00, 32'h600, 32'h600, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0,
                32'h80, 32'h340, 1, 32'h600, 32'h0, 32'h600, 32'h80};

      rst_n = 1'b0;
      clear_events();
      exc_cause = '0; exc_pc = '0; exc_tval = '0;
      mem_valid = 1'b0; mem_pc = '0; gmie = 1'b0;
      mie = '0; mtvec = '0; mepc_in = '0; lsu_busy = 1'b0;

      #12;
      check("rst_stall", {31'b0, stall}, 32'h0);
      check("rst_flush", {31'b0, flush}, 32'h0);
      check("rst_we", {29'b0, mepc_we, mcause_we, mtval_we}, 32'h0);
      check("rst_pulses", {29'b0, mstatus_trap, mstatus_mret, pc_set}, 32'h0);
      check("rst_mux", {31'b0, exc_pc_mux}, {31'b0, EXCPC_MTVEC});
      check("rst_target", trap_target, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         exc_valid = vt[i].exc;      exc_cause = vt[i].cause;
         exc_pc    = vt[i].pc;       exc_tval  = vt[i].tval;
         mret      = vt[i].mret;
         irq_ext   = vt[i].irq[2];   irq_timer = vt[i].irq[1];   irq_sw = vt[i].irq[0];
         gmie      = vt[i].gmie;     mem_valid = vt[i].mem_valid;
         mie       = vt[i].mie;      mem_pc    = vt[i].mem_pc;
         mtvec     = vt[i].mtvec;    mepc_in   = vt[i].mepc_in;
         @(posedge clk);
         #1 clear_events();
         @(negedge clk);
         check($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vt[i].kind != 0});
         check($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vt[i].kind != 0});
         if (vt[i].kind == 1) begin
            @(negedge clk);
            check($sformatf("v%0d_upd_strobes", i),
                  {28'b0, mepc_we, mcause_we, mtval_we, mstatus_trap}, 32'hF);
            check($sformatf("v%0d_mepc", i), mepc_out, vt[i].exp_mepc);
            check($sformatf("v%0d_mcause", i), mcause_out, vt[i].exp_mcause);
            check($sformatf("v%0d_mtval", i), mtval_out, vt[i].exp_mtval);
            @(negedge clk);
            check($sformatf("v%0d_pc_set", i), {31'b0, pc_set}, 32'h1);
            check($sformatf("v%0d_target", i), trap_target, vt[i].exp_target);
            check($sformatf("v%0d_mux", i), {30'b0, exc_pc_mux, mstatus_mret}, 32'h0);
         end else if (vt[i].kind == 2) begin
            @(negedge clk);
            check($sformatf("v%0d_mret_pulses", i), {29'b0, pc_set, mstatus_mret, mepc_we}, 32'h6);
            check($sformatf("v%0d_mux", i), {31'b0, exc_pc_mux}, {31'b0, EXCPC_MEPC});
            check($sformatf("v%0d_target", i), trap_target, vt[i].exp_target);
         end else begin
            @(negedge clk);
            check($sformatf("v%0d_no_strobe", i), {30'b0, mepc_we, pc_set}, 32'h0);
         end
         @(negedge clk);
         check($sformatf("v%0d_idle", i), {30'b0, pc_set, stall}, 32'h0);
      end

      // Exception and external interrupt together, LSU busy for three FLUSH cycles.
      @(negedge clk);
      exc_valid = 1'b1; exc_cause = 5'h05; exc_pc = 32'h700; exc_tval = 32'h1234;
      irq_ext = 1'b1; mie = 32'h800; gmie = 1'b1; mem_valid = 1'b1; mem_pc = 32'h800;
      mtvec = 32'h100; lsu_busy = 1'b1;
      @(posedge clk);
      #1 exc_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("lsu_flush%0d", k), {30'b0, flush, mepc_we}, 32'h2);
         if (k == 2) lsu_busy = 1'b0;
      end
      @(negedge clk);
      check("lsu_exc_mcause", mcause_out, 32'h5);
      check("lsu_exc_mepc", mepc_out, 32'h700);
      @(negedge clk);
      check("lsu_exc_redirect", {31'b0, pc_set}, 32'h1);
      @(negedge clk);
      check("lsu_idle_gap", {30'b0, flush, pc_set}, 32'h0);
      @(negedge clk);
      check("irq_follow_flush", {31'b0, flush}, 32'h1);
      @(negedge clk);
      check("irq_follow_mcause", mcause_out, 32'h8000000B);
      check("irq_follow_mepc", mepc_out, 32'h800);
      check("irq_follow_mtval", mtval_out, 32'h0);
      irq_ext = 1'b0;
      @(negedge clk);
      check("irq_follow_redirect", {31'b0, pc_set}, 32'h1);
      check("irq_follow_target", trap_target, 32'h100);
      @(negedge clk);
      check("irq_follow_idle", {30'b0, flush, pc_set}, 32'h0);

      // Reset asserted in the middle of UPDATE.
      @(negedge clk);
      exc_valid = 1'b1; exc_cause = 5'h02; exc_pc = 32'h900; exc_tval = 32'h0;
      @(posedge clk);
      #1 exc_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstupd_before", {31'b0, mepc_we}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("rstupd_strobes", {27'b0, mepc_we, mcause_we, mtval_we, mstatus_trap, stall}, 32'h0);
      check("rstupd_mepc_data", mepc_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstupd_idle", {29'b0, flush, pc_set, stall}, 32'h0);
      @(negedge clk);
      check("rstupd_no_resume", {29'b0, flush, pc_set, mepc_we}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
